// File: rtl/pc_unit.sv
// Program-counter unit: word-indexed PC with branch/jump/trap/eret handling.
// Define PCU_RAS_EN to build the circular return-address stack for call/return.
module pc_unit #(
    parameter int                   PC_W         = 32,
    parameter int                   IMM_W        = 12,
    parameter int                   STATE_W      = 4,
    parameter logic [STATE_W-1:0]   UPDATE_STATE = 4'b1000,
    parameter logic [PC_W-1:0]      RESET_PC     = '0,
    parameter logic [PC_W-1:0]      TRAP_VEC     = 'h10,
    parameter int                   RAS_DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STATE_W-1:0] estado,
    input  logic [1:0]         pcsrc,
    input  logic               branch_taken,
    input  logic [IMM_W-1:0]   immediate,
    input  logic [PC_W-1:0]    jump_target,
    input  logic               link,
    input  logic               stall,
    input  logic               trap,
    input  logic               eret,
    output logic [PC_W-1:0]    PC,
    output logic [PC_W-1:0]    pc_prev,
    output logic [PC_W-1:0]    epc,
    output logic               in_trap,
    output logic               redirect,
    output logic               misaligned
);

    typedef enum logic {RUN, TRAP} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, prev_q, prev_d, epc_q, epc_d;
    logic            redirect_q, redirect_d, mis_q, mis_d;
    logic [PC_W-1:0] imm_sx, br_off;

    // Byte offset -> word offset: sign-extend, then arithmetic shift by 2.
    assign imm_sx = {{(PC_W-IMM_W){immediate[IMM_W-1]}}, immediate};
    assign br_off = $unsigned($signed(imm_sx) >>> 2);

`ifdef PCU_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0]  ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [PTR_W-1:0] ras_top;
    logic [CNT_W-1:0] ras_cnt;
    logic             push, pop;

    assign ras_top = ras_ptr - PTR_W'(1);

    // ras_ptr points at the next free slot; a push when full overwrites the oldest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else if (push) begin
            ras_q[ras_ptr] <= pc_q + PC_W'(1);
            ras_ptr        <= ras_ptr + PTR_W'(1);
            if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + CNT_W'(1);
        end else if (pop) begin
            ras_ptr <= ras_top;
            ras_cnt <= ras_cnt - CNT_W'(1);
        end
    end
`else
    logic unused_link;
    assign unused_link = link;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        prev_d     = prev_q;
        epc_d      = epc_q;
        redirect_d = 1'b0;
        mis_d      = 1'b0;
`ifdef PCU_RAS_EN
        push       = 1'b0;
        pop        = 1'b0;
`endif
        if (estado == UPDATE_STATE && !stall) begin
            prev_d = pc_q;
            if (trap && state_q == RUN) begin
                epc_d      = pc_q;
                pc_d       = TRAP_VEC;
                state_d    = TRAP;
                redirect_d = 1'b1;
            end else if (eret && state_q == TRAP) begin
                pc_d       = epc_q + PC_W'(1);
                state_d    = RUN;
                redirect_d = 1'b1;
            end else begin
                case (pcsrc)
                    2'b01: begin
                        if (!branch_taken) begin
                            pc_d = pc_q + PC_W'(1);
                        end else if (immediate[1:0] != 2'b00) begin
                            pc_d  = pc_q + PC_W'(1);
                            mis_d = 1'b1;
                        end else begin
                            pc_d       = pc_q + br_off;
                            redirect_d = 1'b1;
                        end
                    end
                    2'b10: begin
                        pc_d       = jump_target;
                        redirect_d = 1'b1;
`ifdef PCU_RAS_EN
                        push       = link;
`endif
                    end
                    2'b11: begin
                        redirect_d = 1'b1;
`ifdef PCU_RAS_EN
                        // Return on an empty stack falls back to the supplied target.
                        if (ras_cnt != '0) begin
                            pc_d = ras_q[ras_top];
                            pop  = 1'b1;
                        end else begin
                            pc_d = jump_target;
                        end
`else
                        pc_d = jump_target;
`endif
                    end
                    default: pc_d = pc_q + PC_W'(1);
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            prev_q     <= RESET_PC;
            epc_q      <= '0;
            redirect_q <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            prev_q     <= prev_d;
            epc_q      <= epc_d;
            redirect_q <= redirect_d;
            mis_q      <= mis_d;
        end
    end

    assign PC         = pc_q;
    assign pc_prev    = prev_q;
    assign epc        = epc_q;
    assign in_trap    = (state_q == TRAP);
    assign redirect   = redirect_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: vector table plus hand sequences for reset and the
// return-address stack (the latter only when PCU_RAS_EN is defined).
module tb_pc_unit;

    localparam logic [3:0] U = 4'b1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  estado = '0;
    logic [1:0]  pcsrc = '0;
    logic        branch_taken = 1'b0;
    logic [11:0] immediate = '0;
    logic [31:0] jump_target = '0;
    logic        link = 1'b0;
    logic        stall = 1'b0;
    logic        trap = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] PC, pc_prev, epc;
    logic        in_trap, redirect, misaligned;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    pc_unit dut (
        .clk(clk), .rst_n(rst_n), .estado(estado), .pcsrc(pcsrc),
        .branch_taken(branch_taken), .immediate(immediate), .jump_target(jump_target),
        .link(link), .stall(stall), .trap(trap), .eret(eret),
        .PC(PC), .pc_prev(pc_prev), .epc(epc), .in_trap(in_trap),
        .redirect(redirect), .misaligned(misaligned)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  est;
        logic [1:0]  src;
        logic        tk;
        logic [11:0] imm;
        logic [31:0] jt;
        logic        stl, trp, ert;
        logic [31:0] pc, epc;
        logic        red, mis, it;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic [3:0] est, logic [1:0] src, logic tk, logic [11:0] imm,
                                logic [31:0] jt, logic stl, logic trp, logic ert,
                                logic [31:0] pc, logic [31:0] e, logic red, logic mis, logic it);
        vec_t v;
        v.est = est; v.src = src; v.tk = tk; v.imm = imm; v.jt = jt;
        v.stl = stl; v.trp = trp; v.ert = ert;
        v.pc = pc; v.epc = e; v.red = red; v.mis = mis; v.it = it;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // driver: apply one cycle of inputs at negedge, sample #1 after the next posedge
    task automatic step(logic [3:0] est, logic [1:0] src, logic tk, logic [11:0] imm,
                        logic [31:0] jt, logic lnk, logic stl, logic trp, logic ert);
        @(negedge clk);
        estado = est; pcsrc = src; branch_taken = tk; immediate = imm;
        jump_target = jt; link = lnk; stall = stl; trap = trp; eret = ert;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        estado = '0; pcsrc = '0; link = 1'b0; stall = 1'b0; trap = 1'b0; eret = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] prev_model;
        logic [31:0] last_pc;

        // est src tk imm jt stl trp ert | pc epc red mis it
        add(U,    2'b00, 0, 12'h000, 32'd0,  0, 0, 0, 32'd1,  32'd0, 0, 0, 0);
        add(U,    2'b00, 0, 12'h000, 32'd0,  0, 0, 0, 32'd2,  32'd0, 0, 0, 0);
        add(U,    2'b00, 0, 12'h000, 32'd0,  0, 0, 0, 32'd3,  32'd0, 0, 0, 0);
        add(4'd0, 2'b10, 0, 12'h000, 32'd50, 0, 0, 0, 32'd3,  32'd0, 0, 0, 0);
        add(U,    2'b10, 0, 12'h000, 32'd50, 1, 1, 0, 32'd3,  32'd0, 0, 0, 0);
        add(U,    2'b10, 0, 12'h000, 32'd10, 0, 0, 0, 32'd10, 32'd0, 1, 0, 0);
        add(U,    2'b01, 1, 12'hFF8, 32'd0,  0, 0, 0, 32'd8,  32'd0, 1, 0, 0);
        add(U,    2'b10, 0, 12'h000, 32'd10, 0, 0, 0, 32'd10, 32'd0, 1, 0, 0);
        add(U,    2'b01, 1, 12'h010, 32'd0,  0, 0, 0, 32'd14, 32'd0, 1, 0, 0);
        add(U,    2'b10, 0, 12'h000, 32'd10, 0, 0, 0, 32'd10, 32'd0, 1, 0, 0);
        add(U,    2'b01, 1, 12'h006, 32'd0,  0, 0, 0, 32'd11, 32'd0, 0, 1, 0);
        add(U,    2'b01, 0, 12'h008, 32'd0,  0, 0, 0, 32'd12, 32'd0, 0, 0, 0);
        add(U,    2'b10, 0, 12'h000, 32'd7,  0, 0, 0, 32'd7,  32'd0, 1, 0, 0);
        add(U,    2'b10, 0, 12'h000, 32'd99, 0, 1, 0, 32'd16, 32'd7, 1, 0, 1);
        add(U,    2'b00, 0, 12'h000, 32'd0,  0, 1, 0, 32'd17, 32'd7, 0, 0, 1);
        add(U,    2'b00, 0, 12'h000, 32'd0,  0, 0, 1, 32'd8,  32'd7, 1, 0, 0);
        add(U,    2'b00, 0, 12'h000, 32'd0,  0, 0, 1, 32'd9,  32'd7, 0, 0, 0);
        add(U,    2'b00, 0, 12'h000, 32'd0,  0, 1, 1, 32'd16, 32'd9, 1, 0, 1);
        add(U,    2'b00, 0, 12'h000, 32'd0,  0, 1, 1, 32'd10, 32'd9, 1, 0, 0);
        add(U,    2'b10, 0, 12'h000, 32'hFFFF_FFFF, 0, 0, 0, 32'hFFFF_FFFF, 32'd9, 1, 0, 0);
        add(U,    2'b00, 0, 12'h000, 32'd0,  0, 0, 0, 32'd0,  32'd9, 0, 0, 0);
        add(U,    2'b01, 1, 12'hFFC, 32'd0,  0, 0, 0, 32'hFFFF_FFFF, 32'd9, 1, 0, 0);
        add(U,    2'b11, 0, 12'h000, 32'd40, 0, 0, 0, 32'd40, 32'd9, 1, 0, 0);

        do_reset();
        #1;
        chk("reset_pc", PC, 32'd0);
        chk("reset_prev", pc_prev, 32'd0);
        chk("reset_epc", epc, 32'd0);
        chk("reset_flags", {29'd0, in_trap, redirect, misaligned}, 32'd0);

        prev_model = 32'd0;
        last_pc = 32'd0;
        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i].pc);
            step(vecs[i].est, vecs[i].src, vecs[i].tk, vecs[i].imm, vecs[i].jt, 1'b0,
                 vecs[i].stl, vecs[i].trp, vecs[i].ert);
            if (vecs[i].est == U && !vecs[i].stl) prev_model = last_pc;
            chk($sformatf("v%0d_pc", i), PC, exp_q.pop_front());
            chk($sformatf("v%0d_prev", i), pc_prev, prev_model);
            chk($sformatf("v%0d_epc", i), epc, vecs[i].epc);
            chk($sformatf("v%0d_flags", i), {29'd0, in_trap, redirect, misaligned},
                {29'd0, vecs[i].it, vecs[i].red, vecs[i].mis});
            last_pc = vecs[i].pc;
        end

        // Asynchronous reset mid-cycle while in TRAP with an update pending.
        do_reset();
        step(U, 2'b00, 0, 12'h0, 32'd0, 0, 0, 1, 0);
        chk("arst_pre_trap", {31'd0, in_trap}, 32'd1);
        @(negedge clk);
        estado = U; pcsrc = 2'b10; jump_target = 32'd99; trap = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc", PC, 32'd0);
        chk("arst_trap", {31'd0, in_trap}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("arst_hold", PC, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_release", PC, 32'd99);

`ifdef PCU_RAS_EN
        do_reset();
        step(U, 2'b10, 0, 12'h0, 32'd5,   0, 0, 0, 0);
        step(U, 2'b10, 0, 12'h0, 32'd100, 1, 0, 0, 0);
        chk("ras_call1", PC, 32'd100);
        step(U, 2'b10, 0, 12'h0, 32'd20,  0, 0, 0, 0);
        step(U, 2'b10, 0, 12'h0, 32'd200, 1, 0, 0, 0);
        chk("ras_call2", PC, 32'd200);
        step(U, 2'b11, 0, 12'h0, 32'd0,   0, 0, 0, 0);
        chk("ras_pop1", PC, 32'd21);
        chk("ras_pop1_red", {31'd0, redirect}, 32'd1);
        step(U, 2'b11, 0, 12'h0, 32'd0,   0, 0, 0, 0);
        chk("ras_pop2", PC, 32'd6);
        step(U, 2'b11, 0, 12'h0, 32'd77,  0, 0, 0, 0);
        chk("ras_pop_empty", PC, 32'd77);
        // Five calls into a four-deep stack: the first return address (78) is lost.
        for (int k = 1; k <= 5; k++) step(U, 2'b10, 0, 12'h0, 32'(k), 1, 0, 0, 0);
        for (int k = 5; k >= 2; k--) begin
            step(U, 2'b11, 0, 12'h0, 32'd0, 0, 0, 0, 0);
            chk($sformatf("ras_ovf_pop%0d", k), PC, 32'(k));
        end
        step(U, 2'b11, 0, 12'h0, 32'd333, 0, 0, 0, 0);
        chk("ras_ovf_empty", PC, 32'd333);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the multicycle core.
- Replaces fixed-width PC increment/branch logic with configurable widths and a signed two's-complement branch offset.
- Adds absolute jumps, stall, trap entry/return with saved EPC, a misalignment check and a redirect pulse.
- Sits between the control FSM (supplies `estado`) and instruction fetch (consumes `PC`).

Parameters:
- PC_W, 32, PC width in bits. PC is a word index: +1 = next instruction.
- IMM_W, 12, branch offset width. Offset is signed, in bytes.
- STATE_W, 4, width of `estado`.
- UPDATE_STATE, 4'b1000, `estado` value in which the PC may update.
- RESET_PC, 0, PC value on reset.
- TRAP_VEC, 32'h10, word index loaded on trap entry.
- RAS_DEPTH, 4, return-stack entries. Used only with PCU_RAS_EN; power of 2, ≥2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- estado  in  STATE_W  current control-FSM state
- pcsrc  in  2  00 seq, 01 branch, 10 jump, 11 return
- branch_taken  in  1  qualifies pcsrc=01
- immediate  in  IMM_W  signed byte offset for branch
- jump_target  in  PC_W  absolute word index for pcsrc=10/11
- link  in  1  with pcsrc=10, marks a call (RAS push)
- stall  in  1  blocks all PC updates
- trap  in  1  trap request
- eret  in  1  return from trap
- PC  out  PC_W  current instruction word index
- pc_prev  out  PC_W  PC before last update
- epc  out  PC_W  saved PC on trap entry
- in_trap  out  1  FSM in TRAP
- redirect  out  1  one-cycle pulse: last update was non-sequential
- misaligned  out  1  one-cycle pulse: branch offset not multiple of 4

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC; pc_prev=RESET_PC; epc=0.
  - in_trap=0; redirect=0; misaligned=0; FSM=RUN; RAS empty.
  - Takes effect immediately, including mid-update.
- Update gating:
  - Update occurs only on a posedge with estado==UPDATE_STATE and stall=0.
  - Otherwise all registers hold; redirect and misaligned go to 0.
- Priority within an update cycle (one action per cycle):
  1. trap, in RUN:
     - epc<=PC; PC<=TRAP_VEC; FSM->TRAP; redirect=1.
     - pcsrc ignored.
     - A trap while already in TRAP is ignored; normal flow continues.
  2. eret, in TRAP:
     - PC<=epc+1; FSM->RUN; redirect=1.
     - eret in RUN is ignored.
  3. pcsrc=00, or pcsrc=01 with branch_taken=0: PC<=PC+1.
  4. pcsrc=01 with branch_taken=1:
     - off = sign-extend(immediate) arithmetically shifted right by 2.
     - If immediate[1:0]!=0: PC<=PC+1, misaligned=1, redirect=0.
     - Else PC<=PC+off, redirect=1.
  5. pcsrc=10: PC<=jump_target; redirect=1.
  6. pcsrc=11: see Optional Feature.
- Arithmetic:
  - All PC arithmetic is modulo 2^PC_W.
  - Wrap-around is silent: PC=all-ones +1 -> 0; PC=0 + off=-1 -> all-ones.
- pc_prev<=PC on every performed update, including traps.
- Latency: new PC visible the cycle after the update edge. redirect and misaligned are valid for exactly that cycle.
- trap and eret both high in TRAP: eret wins, since trap is ignored in TRAP.

Optional Feature:
- Macro PCU_RAS_EN.
- Defined:
  - Circular return-address stack of RAS_DEPTH entries, PC_W bits each.
  - pcsrc=10 with link=1 pushes PC+1.
  - pcsrc=11 pops: PC<=top; redirect=1.
  - Push when full overwrites the oldest entry.
  - Pop when empty uses jump_target instead and the count stays 0.
  - Trap entry does not touch the stack.
- Not defined:
  - No stack is built; link is ignored.
  - pcsrc=11 behaves identically to pcsrc=10.

Test Plan:
- Reset, then 3 update cycles with pcsrc=00 -> PC=0,1,2,3. With estado=0 or stall=1, PC holds at 3 and redirect=0.
- PC=10, pcsrc=01, taken, immediate=12'hFF8 (-8) -> PC=8, redirect=1 for one cycle. immediate=12'h010 -> PC=14. immediate=12'h006 -> PC=11, misaligned=1.
- PC=7, trap=1 -> PC=TRAP_VEC=16, epc=7, in_trap=1. Second trap -> ignored, PC=17. eret -> PC=8, in_trap=0.
- PC=2^PC_W-1, pcsrc=00 -> PC=0. PC=0, branch immediate=-4 -> PC=all-ones.
- With PCU_RAS_EN:
  - Calls from PC=5 and PC=20 with targets 100 and 200.
  - Two pcsrc=11 pops -> PC=21, then 6.
  - Third pop on empty -> PC=jump_target.
  - RAS_DEPTH+1 pushes -> oldest entry lost.
- rst_n asserted low mid-cycle, between clock edges, while estado==UPDATE_STATE -> PC=RESET_PC at once, in_trap=0, no further update until rst_n is deasserted.
